// File: rtl/mem_window_fetcher_pkg.sv
// Shared constants and state encoding for the instruction-window fetcher.
package mem_window_fetcher_pkg;
  localparam int BYTE          = 8;
  localparam int MEM_ADDR_SIZE = 16;
  localparam int WINDOW_BYTES  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } fetch_win_state_t;
endpackage

// File: rtl/mem_window_fetcher_if.sv
// CPU request/response and byte-bus signals of the window fetcher.
interface mem_window_fetcher_if #(
  parameter int MEM_ADDR_SIZE = mem_window_fetcher_pkg::MEM_ADDR_SIZE,
  parameter int WINDOW_BYTES  = mem_window_fetcher_pkg::WINDOW_BYTES
);
  import mem_window_fetcher_pkg::*;

  logic                          req_valid_i;
  logic [MEM_ADDR_SIZE-1:0]      req_addr_i;
  logic                          req_ready_o;
  logic                          rsp_valid_o;
  logic [WINDOW_BYTES*BYTE-1:0]  rsp_data_o;
  logic                          flush_i;
  logic                          bus_rd_o;
  logic [MEM_ADDR_SIZE-1:0]      bus_addr_o;
  logic [BYTE-1:0]               bus_data_i;
  logic                          bus_ack_i;

  // master: CPU side plus memory bus; slave: the fetcher itself
  modport master (
    output req_valid_i, req_addr_i, flush_i, bus_data_i, bus_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, bus_rd_o, bus_addr_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, flush_i, bus_data_i, bus_ack_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, bus_rd_o, bus_addr_o
  );
endinterface

// File: rtl/mem_window_fetcher.sv
// Fetches a WINDOW_BYTES instruction window over a byte bus, with a
// one-entry window cache so repeated requests skip the bus entirely.
module mem_window_fetcher #(
  parameter int MEM_ADDR_SIZE = mem_window_fetcher_pkg::MEM_ADDR_SIZE,
  parameter int WINDOW_BYTES  = mem_window_fetcher_pkg::WINDOW_BYTES
) (
  input logic                 clk_i,
  input logic                 rstn_i,
  mem_window_fetcher_if.slave bus
);
  import mem_window_fetcher_pkg::*;

  localparam int CNT_W = (WINDOW_BYTES > 1) ? $clog2(WINDOW_BYTES) : 1;
  localparam int WIN_W = WINDOW_BYTES * BYTE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_BYTES - 1);

  fetch_win_state_t         state_q;
  logic [MEM_ADDR_SIZE-1:0] base_q;
  logic [MEM_ADDR_SIZE-1:0] cache_base_q;
  logic                     cache_vld_q;
  logic                     flush_pend_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [WIN_W-1:0]         win_q;
  logic                     hit;

  assign hit            = cache_vld_q && (bus.req_addr_i == cache_base_q) && !bus.flush_i;
  assign bus.rsp_data_o = win_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      bus.req_ready_o <= 1'b1;
      bus.rsp_valid_o <= 1'b0;
      bus.bus_rd_o    <= 1'b0;
      bus.bus_addr_o  <= '0;
      win_q           <= '0;
      cnt_q           <= '0;
      base_q          <= '0;
      cache_base_q    <= '0;
      cache_vld_q     <= 1'b0;
      flush_pend_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush_i) cache_vld_q <= 1'b0;
          if (bus.req_valid_i) begin
            base_q          <= bus.req_addr_i;
            bus.req_ready_o <= 1'b0;
            if (hit) begin
              state_q         <= RESP;
              bus.rsp_valid_o <= 1'b1;
            end else begin
              state_q        <= FETCH;
              cnt_q          <= '0;
              bus.bus_rd_o   <= 1'b1;
              bus.bus_addr_o <= bus.req_addr_i;
            end
          end
        end
        FETCH: begin
          if (bus.flush_i) begin
            cache_vld_q  <= 1'b0;
            flush_pend_q <= 1'b1;
          end
          if (bus.bus_ack_i && bus.bus_rd_o) begin
            for (int k = 0; k < WINDOW_BYTES; k++) begin
              if (cnt_q == CNT_W'(k)) win_q[k*BYTE +: BYTE] <= bus.bus_data_i;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              // A flush seen at any point in the fetch keeps this window uncached
              bus.bus_rd_o    <= 1'b0;
              cache_vld_q     <= !(flush_pend_q || bus.flush_i);
              cache_base_q    <= base_q;
              state_q         <= RESP;
              bus.rsp_valid_o <= 1'b1;
            end else begin
              bus.bus_addr_o <= base_q + MEM_ADDR_SIZE'(cnt_q) + MEM_ADDR_SIZE'(1);
            end
          end
        end
        RESP: begin
          if (bus.flush_i) cache_vld_q <= 1'b0;
          bus.rsp_valid_o <= 1'b0;
          bus.req_ready_o <= 1'b1;
          flush_pend_q    <= 1'b0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_window_fetcher.sv
// Directed bench for mem_window_fetcher with a wait-state byte memory model.
module tb_mem_window_fetcher;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_window_fetcher_if #(.MEM_ADDR_SIZE(16), .WINDOW_BYTES(3)) bus_if ();

  mem_window_fetcher #(.MEM_ADDR_SIZE(16), .WINDOW_BYTES(3)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus_if)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  int          waits = 0;
  int          wcnt = 0;
  int          rd_cycles = 0;
  logic        resp_ack = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        stray_ack = 1'b0;
  logic [7:0]  stray_data = 8'h00;
  logic [15:0] addr_log [$];

  assign bus_if.bus_ack_i  = resp_ack | stray_ack;
  assign bus_if.bus_data_i = stray_ack ? stray_data : resp_data;

  // Memory responder: acks after `waits` idle cycles of bus_rd_o
  always @(negedge clk) begin
    if (bus_if.bus_rd_o === 1'b1) begin
      rd_cycles++;
      if (wcnt >= waits) begin
        resp_ack  = 1'b1;
        resp_data = mem[bus_if.bus_addr_o];
        addr_log.push_back(bus_if.bus_addr_o);
        wcnt      = 0;
      end else begin
        resp_ack = 1'b0;
        wcnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wcnt     = 0;
    end
  end

  task automatic issue(input logic [15:0] a);
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready addr=%h got=%b want=1", a, bus_if.req_ready_o);
    end
    bus_if.req_valid_i = 1'b1;
    bus_if.req_addr_i  = a;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (bus_if.rsp_valid_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_window(input string name, input logic [15:0] a, input int exp_lat,
                              input int exp_rd, input logic [23:0] exp_data);
    int lat;
    int rd0;
    rd0 = rd_cycles;
    issue(a);
    wait_rsp(1, lat);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    checks++;
    if (bus_if.rsp_data_o !== exp_data) begin
      failures++;
      $display("FAIL %s_data got=%h want=%h", name, bus_if.rsp_data_o, exp_data);
    end
    @(negedge clk);
    checks++;
    if (bus_if.rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse got=%b want=0", name, bus_if.rsp_valid_o);
    end
    checks++;
    if (rd_cycles - rd0 !== exp_rd) begin
      failures++;
      $display("FAIL %s_rd_cycles got=%0d want=%0d", name, rd_cycles - rd0, exp_rd);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.bus_rd_o} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=100",
               {bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.bus_rd_o});
    end
    checks++;
    if (bus_if.rsp_data_o !== 24'h0 || bus_if.bus_addr_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h want=0/0", bus_if.rsp_data_o, bus_if.bus_addr_o);
    end
    rstn = 1'b1;
  endtask

  task automatic test_miss();
    int s0;
    waits = 0;
    s0 = addr_log.size();
    check_window("miss", 16'h8000, 4, 3, 24'h0042A9);
    checks++;
    if (addr_log.size() != s0 + 3 || addr_log[s0] !== 16'h8000 ||
        addr_log[s0+1] !== 16'h8001 || addr_log[s0+2] !== 16'h8002) begin
      failures++;
      $display("FAIL miss_addrs got_n=%0d want=8000,8001,8002", addr_log.size() - s0);
    end
  endtask

  task automatic test_hit();
    check_window("hit", 16'h8000, 1, 0, 24'h0042A9);
  endtask

  task automatic test_wait_wrap();
    int s0;
    waits = 2;
    s0 = addr_log.size();
    check_window("wrap", 16'hFFFF, 10, 9, 24'h332211);
    checks++;
    if (addr_log.size() != s0 + 3 || addr_log[s0] !== 16'hFFFF ||
        addr_log[s0+1] !== 16'h0000 || addr_log[s0+2] !== 16'h0001) begin
      failures++;
      $display("FAIL wrap_addrs got_n=%0d want=ffff,0000,0001", addr_log.size() - s0);
    end
    waits = 0;
  endtask

  task automatic test_flush();
    int lat;
    issue(16'h8000);
    bus_if.flush_i = 1'b1;
    @(negedge clk);
    bus_if.flush_i = 1'b0;
    wait_rsp(2, lat);
    checks++;
    if (lat !== 4 || bus_if.rsp_data_o !== 24'h0042A9) begin
      failures++;
      $display("FAIL flush_window got=%0d/%h want=4/0042a9", lat, bus_if.rsp_data_o);
    end
    @(negedge clk);
    check_window("flush_refetch", 16'h8000, 4, 3, 24'h0042A9);
  endtask

  task automatic test_reset_mid_fetch();
    issue(16'h2000);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if ({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.bus_rd_o} !== 3'b100 ||
        bus_if.rsp_data_o !== 24'h0) begin
      failures++;
      $display("FAIL midreset_state got=%b data=%h want=100 data=0",
               {bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.bus_rd_o}, bus_if.rsp_data_o);
    end
    stray_data = 8'hEE;
    stray_ack  = 1'b1;
    @(negedge clk);
    stray_ack  = 1'b0;
    checks++;
    if ({bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.bus_rd_o} !== 3'b100 ||
        bus_if.rsp_data_o !== 24'h0) begin
      failures++;
      $display("FAIL stray_ack got=%b data=%h want=100 data=0",
               {bus_if.req_ready_o, bus_if.rsp_valid_o, bus_if.bus_rd_o}, bus_if.rsp_data_o);
    end
    check_window("post_reset", 16'h8000, 4, 3, 24'h0042A9);
  endtask

  task automatic test_back_to_back();
    logic [6:1] ready_seen;
    logic [6:1] rsp_seen;
    int rd0;
    rd0 = rd_cycles;
    @(negedge clk);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_addr_i  = 16'h2000;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ready_seen[k] = bus_if.req_ready_o;
      rsp_seen[k]   = bus_if.rsp_valid_o;
      if (k == 4) begin
        checks++;
        if (bus_if.rsp_data_o !== 24'h7EC35A) begin
          failures++;
          $display("FAIL b2b_data got=%h want=7ec35a", bus_if.rsp_data_o);
        end
      end
    end
    bus_if.req_valid_i = 1'b0;
    checks++;
    if (ready_seen !== 6'b010000) begin
      failures++;
      $display("FAIL b2b_ready got=%b want=010000", ready_seen);
    end
    checks++;
    if (rsp_seen !== 6'b101000) begin
      failures++;
      $display("FAIL b2b_rsp got=%b want=101000", rsp_seen);
    end
    checks++;
    if (rd_cycles - rd0 !== 3) begin
      failures++;
      $display("FAIL b2b_rd_cycles got=%0d want=3", rd_cycles - rd0);
    end
    @(negedge clk);
    checks++;
    if (bus_if.rsp_data_o !== 24'h7EC35A || bus_if.rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold got=%h/%b want=7ec35a/0", bus_if.rsp_data_o, bus_if.rsp_valid_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h8002] = 8'h00;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22; mem[16'h0001] = 8'h33;
    mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'hC3; mem[16'h2002] = 8'h7E;
    bus_if.req_valid_i = 1'b0;
    bus_if.req_addr_i  = 16'h0;
    bus_if.flush_i     = 1'b0;

    test_reset();
    test_miss();
    test_hit();
    test_wait_wrap();
    test_flush();
    test_reset_mid_fetch();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
